// File: rtl/game_pkg.sv
// Shared types and helpers for the game score/flow controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: FSM state enum, BCD digit width, screen geometry,
//           saturating 3-digit BCD increment and BCD greater-than compare.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int BCD_W    = 4;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [3*BCD_W-1:0] bcd3_t;

    // Ripple increment of {hundreds,tens,ones}; 999 holds at 999.
    function automatic bcd3_t bcd3_inc(input bcd3_t v);
        logic [BCD_W-1:0] h;
        logic [BCD_W-1:0] t;
        logic [BCD_W-1:0] o;
        {h, t, o} = v;
        if (v == 12'h999) begin
            return v;
        end
        if (o == 4'd9) begin
            o = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                h = h + 4'd1;
            end else begin
                t = t + 4'd1;
            end
        end else begin
            o = o + 4'd1;
        end
        return {h, t, o};
    endfunction

    // a > b, compared digit by digit from the hundreds down.
    function automatic logic bcd3_gt(input bcd3_t a, input bcd3_t b);
        for (int d = 2; d >= 0; d--) begin
            if (a[d*BCD_W +: BCD_W] != b[d*BCD_W +: BCD_W]) begin
                return a[d*BCD_W +: BCD_W] > b[d*BCD_W +: BCD_W];
            end
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous push-button plus rising-edge pulse.
// Latency: pulse is visible after the 2nd edge and acted on at the 3rd.
// Backpressure: none; one single-cycle pulse per press.
// Ports: clk, reset (sync, active-high), btn (async pin), rise (1-cycle pulse).
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/game_score_ctrl.sv
// Game-flow controller: per-frame hit/miss events, 3-digit BCD score, lives, pause.
// Latency: events take effect on the end-of-frame cycle; start button 3 edges.
// Backpressure: none; at most one hit and one miss are counted per frame.
// Ports: clk25/Reset (sync, active-high), xpos/ypos (raster position),
//        score/missedO (from game module), start_btn (async), pause, score_bcd,
//        lives, game_over, state_o (IDLE=0 PLAY=1 HOLD=2 OVER=3).
// Optional: define HISCORE_EN to add hiscore_bcd, latched on entry to OVER.
module game_score_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT  = 3,
    parameter int HOLD_FRAMES = 60,
    parameter int EOF_Y       = SCREEN_H
) (
    input  logic        clk25,
    input  logic        Reset,
    input  logic [9:0]  xpos,
    input  logic [9:0]  ypos,
    input  logic        score,
    input  logic        missedO,
    input  logic        start_btn,
    output logic        pause,
    output logic [11:0] score_bcd,
    output logic [2:0]  lives,
`ifdef HISCORE_EN
    output logic [11:0] hiscore_bcd,
`endif
    output logic        game_over,
    output logic [1:0]  state_o
);

    localparam logic [2:0] LIVES_LD = 3'(LIVES_INIT);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_FRAMES);

    state_t     state;
    logic       start_rise;
    logic       eof;
    logic       score_q;
    logic       missed_q;
    logic       hit_pend;
    logic       miss_pend;
    logic [7:0] hold_cnt;
    bcd3_t      score_next;

    btn_sync_edge u_start (
        .clk   (clk25),
        .reset (Reset),
        .btn   (start_btn),
        .rise  (start_rise)
    );

    assign eof     = (xpos == 10'd0) && (ypos == 10'(EOF_Y));
    assign state_o = state;

    // Score as it stands after this frame's hit, so a hit in the miss frame
    // is already included when the game ends.
    assign score_next = hit_pend ? bcd3_inc(score_bcd) : score_bcd;

    // Edge-detected event flags, collapsed to one per frame and dropped at eof.
    always_ff @(posedge clk25) begin
        if (Reset) begin
            score_q   <= 1'b0;
            missed_q  <= 1'b0;
            hit_pend  <= 1'b0;
            miss_pend <= 1'b0;
        end else begin
            score_q  <= score;
            missed_q <= missedO;
            if (eof) begin
                hit_pend  <= 1'b0;
                miss_pend <= 1'b0;
            end else begin
                hit_pend  <= hit_pend  | (score & ~score_q);
                miss_pend <= miss_pend | (missedO & ~missed_q);
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (Reset) begin
            state       <= IDLE;
            pause       <= 1'b1;
            game_over   <= 1'b0;
            score_bcd   <= '0;
            lives       <= LIVES_LD;
            hold_cnt    <= '0;
`ifdef HISCORE_EN
            hiscore_bcd <= '0;
`endif
        end else begin
            case (state)
                IDLE, OVER: begin
                    if (start_rise) begin
                        score_bcd <= '0;
                        lives     <= LIVES_LD;
                        state     <= PLAY;
                        pause     <= 1'b0;
                        game_over <= 1'b0;
                    end
                end
                PLAY: begin
                    if (eof) begin
                        score_bcd <= score_next;
                        if (miss_pend) begin
                            lives <= lives - 3'd1;
                            pause <= 1'b1;
                            if (lives == 3'd1) begin
                                state     <= OVER;
                                game_over <= 1'b1;
`ifdef HISCORE_EN
                                if (bcd3_gt(score_next, hiscore_bcd)) begin
                                    hiscore_bcd <= score_next;
                                end
`endif
                            end else begin
                                hold_cnt <= HOLD_LD;
                                state    <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (eof) begin
                        if (hold_cnt == 8'd1) begin
                            hold_cnt <= '0;
                            state    <= PLAY;
                            pause    <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    pause <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_score_ctrl.sv
module tb_game_score_ctrl;

    localparam int LIVES  = 3;
    localparam int HOLD_N = 60;

    logic        clk25     = 1'b0;
    logic        Reset     = 1'b1;
    logic [9:0]  xpos      = 10'd100;
    logic [9:0]  ypos      = 10'd100;
    logic        score     = 1'b0;
    logic        missedO   = 1'b0;
    logic        start_btn = 1'b0;
    logic        pause;
    logic [11:0] score_bcd;
    logic [2:0]  lives;
    logic        game_over;
    logic [1:0]  state_o;
`ifdef HISCORE_EN
    logic [11:0] hiscore_bcd;
`endif

    game_score_ctrl dut (
        .clk25       (clk25),
        .Reset       (Reset),
        .xpos        (xpos),
        .ypos        (ypos),
        .score       (score),
        .missedO     (missedO),
        .start_btn   (start_btn),
        .pause       (pause),
        .score_bcd   (score_bcd),
        .lives       (lives),
`ifdef HISCORE_EN
        .hiscore_bcd (hiscore_bcd),
`endif
        .game_over   (game_over),
        .state_o     (state_o)
    );

    always #20 clk25 = ~clk25;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: plain integers, states by number.
    int m_state, m_score, m_lives, m_hold, m_hi;

    typedef struct {
        int nh;
        bit ms;
        int e_state;
        int e_score;
        int e_lives;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    task automatic chk_all(input string tag, input int st, input int sc, input int lv);
        chk({tag, ".state"}, int'(state_o), st);
        chk({tag, ".score"}, int'(score_bcd), sc);
        chk({tag, ".lives"}, int'(lives), lv);
        chk({tag, ".pause"}, int'(pause), (st == 1) ? 0 : 1);
        chk({tag, ".game_over"}, int'(game_over), (st == 3) ? 1 : 0);
    endtask

    task automatic chk_hi(input string tag, input int exp);
`ifdef HISCORE_EN
        chk({tag, ".hiscore"}, int'(hiscore_bcd), exp);
`else
        if (exp < 0) $display("note %s", tag);
`endif
    endtask

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    // One short synthetic frame: nh score pulses, optional missedO edge, then eof.
    task automatic frame(input int nh, input bit ms);
        xpos = 10'd100; ypos = 10'd100; score = 1'b0; missedO = 1'b0;
        step();
        for (int i = 0; i < nh; i++) begin
            score = 1'b1; step();
            score = 1'b0; step();
        end
        if (ms) begin
            missedO = 1'b1; step(); step();
            missedO = 1'b0; step();
        end
        xpos = 10'd0; ypos = 10'd480;
        step();
        xpos = 10'd100; ypos = 10'd100;
    endtask

    task automatic start_pulse();
        start_btn = 1'b1;
        repeat (4) step();
        start_btn = 1'b0;
        repeat (4) step();
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_lives = LIVES; m_hold = 0; m_hi = 0;
    endtask

    task automatic model_start();
        if (m_state == 0 || m_state == 3) begin
            m_state = 1; m_score = 0; m_lives = LIVES;
        end
    endtask

    task automatic model_frame(input int nh, input bit ms);
        if (m_state == 1) begin
            if (nh > 0 && m_score < 999) m_score++;
            if (ms) begin
                m_lives--;
                if (m_lives == 0) begin
                    m_state = 3;
                    if (m_score > m_hi) m_hi = m_score;
                end else begin
                    m_state = 2;
                    m_hold  = HOLD_N;
                end
            end
        end else if (m_state == 2) begin
            m_hold--;
            if (m_hold == 0) m_state = 1;
        end
    endtask

    initial begin
        tbl[0] = '{3, 1'b0, 1, 'h001, 3};
        tbl[1] = '{1, 1'b0, 1, 'h002, 3};
        tbl[2] = '{0, 1'b0, 1, 'h002, 3};
        tbl[3] = '{2, 1'b0, 1, 'h003, 3};
        tbl[4] = '{1, 1'b1, 2, 'h004, 2};

        // Reset
        step(); step();
        Reset = 1'b0;
        chk_all("reset", 0, 'h000, 3);
        chk_hi("reset", 'h000);

        // Start within 4 cycles
        start_btn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (state_o == 2'd1) break;
        end
        chk("start.state", int'(state_o), 1);
        chk("start.pause", int'(pause), 0);
        start_btn = 1'b0;
        repeat (4) step();

        // Table of frames
        for (int i = 0; i < 5; i++) begin
            frame(tbl[i].nh, tbl[i].ms);
            chk_all($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_score, tbl[i].e_lives);
        end

        // Hold-off: hits ignored, exactly HOLD_N eofs
        repeat (HOLD_N - 1) frame(1, 1'b0);
        chk_all("hold59", 2, 'h004, 2);
        frame(0, 1'b0);
        chk_all("hold_exit", 1, 'h004, 2);

        // BCD ripple and saturation
        repeat (95) frame(1, 1'b0);
        chk_all("s099", 1, 'h099, 2);
        frame(1, 1'b0);
        chk_all("s100", 1, 'h100, 2);
        repeat (899) frame(1, 1'b0);
        chk_all("s999", 1, 'h999, 2);
        frame(1, 1'b0);
        chk_all("sat", 1, 'h999, 2);

        // Remaining lives to game over
        frame(0, 1'b1);
        chk_all("miss2", 2, 'h999, 1);
        repeat (HOLD_N) frame(0, 1'b0);
        chk_all("back", 1, 'h999, 1);
        frame(0, 1'b1);
        chk_all("over", 3, 'h999, 0);
        chk_hi("over", 'h999);
        start_pulse();
        chk_all("restart", 1, 'h000, 3);
        chk_hi("restart", 'h999);

        // Hit and miss in the same frame, then reset mid-hold
        repeat (5) frame(1, 1'b0);
        frame(0, 1'b1);
        chk_all("pre_hm", 2, 'h005, 2);
        repeat (HOLD_N) frame(0, 1'b0);
        frame(1, 1'b1);
        chk_all("hitmiss", 2, 'h006, 1);
        Reset = 1'b1;
        step();
        chk_all("rst_hold", 0, 'h000, 3);
        chk_hi("rst_hold", 'h000);
        Reset = 1'b0;
        frame(0, 1'b0);
        chk_all("rst_idle", 0, 'h000, 3);

        // Game ending at 042
        start_pulse();
        repeat (42) frame(1, 1'b0);
        repeat (2) begin
            frame(0, 1'b1);
            repeat (HOLD_N) frame(0, 1'b0);
        end
        frame(0, 1'b1);
        chk_all("over42", 3, 'h042, 0);
        chk_hi("over42", 'h042);
        start_pulse();
        chk_all("restart42", 1, 'h000, 3);
        chk_hi("restart42", 'h042);

        // Randomized play against the model
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        model_reset();
        for (int it = 0; it < 800; it++) begin
            int r;
            int nh;
            bit ms;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                start_pulse();
                model_start();
            end else begin
                nh = (r < 8) ? 0 : int'($urandom_range(1, 3));
                ms = (r >= 17);
                frame(nh, ms);
                model_frame(nh, ms);
            end
            chk_all("rand", m_state, to_bcd(m_score), m_lives);
            chk_hi("rand", to_bcd(m_hi));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
